// File: rtl/grover_pkg.sv
// Shared definitions for the Grover diffusion mean accumulator: default sizing,
// FSM state encoding and saturation bounds for the default data width.
package grover_pkg;

  localparam int unsigned DEF_NUM_QUBIT  = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned N              = 2 ** DEF_NUM_QUBIT;
  localparam int unsigned ACC_WIDTH      = DEF_DATA_WIDTH + DEF_NUM_QUBIT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2
  } state_e;

  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/grover_mean_scale.sv
// Combinational acc -> 2*mean: optional round-half-up, arithmetic shift, saturation.
// GROVER_MEAN_ROUND_EN selects rounding; otherwise the shift truncates toward -inf.
module grover_mean_scale #(
  parameter int unsigned NUM_QUBIT  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned ACC_W     = DATA_WIDTH + NUM_QUBIT
) (
  input  logic signed [ACC_W-1:0]      acc,
  output logic        [DATA_WIDTH-1:0] two_mean
);

  // One guard bit above ACC_W so the rounding bias can never wrap.
  localparam logic signed [ACC_W:0] SatMax =
    {{(ACC_W-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] SatMin =
    {{(ACC_W-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    biased = {acc[ACC_W-1], acc};
`ifdef GROVER_MEAN_ROUND_EN
    biased = biased + (ACC_W+1)'(2 ** (NUM_QUBIT - 2));
`endif
    shifted = biased >>> (NUM_QUBIT - 1);
    if (shifted > SatMax) begin
      two_mean = SatMax[DATA_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      two_mean = SatMin[DATA_WIDTH-1:0];
    end else begin
      two_mean = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/grover_mean_acc.sv
// Sequential 2*mean accumulator over a 2**NUM_QUBIT amplitude vector with start/valid
// handshake. Rounding is selected in grover_mean_scale via GROVER_MEAN_ROUND_EN.
module grover_mean_acc
  import grover_pkg::*;
#(
  parameter int unsigned NUM_QUBIT      = DEF_NUM_QUBIT,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ELEM_PER_CYCLE = 1,
  localparam int unsigned NUM_AMP       = 2 ** NUM_QUBIT,
  localparam int unsigned ACC_W         = DATA_WIDTH + NUM_QUBIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_WIDTH*NUM_AMP-1:0] amp_in,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         two_mean_out,
  output logic                          valid_out
);

  state_e                        state_q, state_d;
  logic [DATA_WIDTH*NUM_AMP-1:0] vec_q;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [NUM_QUBIT-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]         two_mean_q, two_mean_d;
  logic                          valid_q, valid_d;
  logic                          capture;
  logic signed [ACC_W-1:0]       step_sum;
  logic signed [DATA_WIDTH-1:0]  elem;
  logic [DATA_WIDTH-1:0]         scaled;

  grover_mean_scale #(
    .NUM_QUBIT  (NUM_QUBIT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_scale (
    .acc      (acc_q),
    .two_mean (scaled)
  );

  always_comb begin
    step_sum = '0;
    elem     = '0;
    for (int e = 0; e < int'(ELEM_PER_CYCLE); e++) begin
      elem     = vec_q[DATA_WIDTH*(int'(idx_q)+e) +: DATA_WIDTH];
      step_sum = step_sum + ACC_W'(elem);
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    two_mean_d = two_mean_q;
    valid_d    = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The valid cycle still counts as busy, so a start there is dropped.
        if (start && !valid_q) begin
          capture = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + step_sum;
        idx_d = idx_q + NUM_QUBIT'(ELEM_PER_CYCLE);
        if (idx_q == NUM_QUBIT'(NUM_AMP - ELEM_PER_CYCLE)) begin
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        two_mean_d = scaled;
        valid_d    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      two_mean_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      two_mean_q <= two_mean_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      vec_q <= amp_in;
    end
  end

  assign busy         = (state_q != ST_IDLE) || valid_q;
  assign two_mean_out = two_mean_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_grover_mean_acc.sv
// Directed self-checking bench for grover_mean_acc (ELEM_PER_CYCLE 1 and 4 instances).
// Expected values follow GROVER_MEAN_ROUND_EN when the bench is built with it.
module tb_grover_mean_acc;

  localparam int DW = 32;
  localparam int NA = 16;

  logic             clk = 1'b0;
  logic             rst, start, start4;
  logic [DW*NA-1:0] amp_in, amp4;
  logic             busy, valid_out, busy4, valid4;
  logic [DW-1:0]    two_mean_out, two_mean4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grover_mean_acc #(
    .NUM_QUBIT      (4),
    .DATA_WIDTH     (DW),
    .ELEM_PER_CYCLE (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .amp_in       (amp_in),
    .busy         (busy),
    .two_mean_out (two_mean_out),
    .valid_out    (valid_out)
  );

  grover_mean_acc #(
    .NUM_QUBIT      (4),
    .DATA_WIDTH     (DW),
    .ELEM_PER_CYCLE (4)
  ) dut4 (
    .clk          (clk),
    .rst          (rst),
    .start        (start4),
    .amp_in       (amp4),
    .busy         (busy4),
    .two_mean_out (two_mean4),
    .valid_out    (valid4)
  );

  function automatic logic [DW*NA-1:0] fill(input logic [DW-1:0] v);
    logic [DW*NA-1:0] r;
    for (int j = 0; j < NA; j++) r[DW*j +: DW] = v;
    return r;
  endfunction

  // amp[j] = j + off
  function automatic logic [DW*NA-1:0] ramp(input int off);
    logic [DW*NA-1:0] r;
    for (int j = 0; j < NA; j++) r[DW*j +: DW] = DW'(j + off);
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [DW*NA-1:0] v, input string tag, input logic [DW-1:0] exp);
    int cyc;
    amp_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    amp_in = fill(32'h5A5A_5A5A);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!valid_out && cyc < 40);
    check({tag, "_latency"}, DW'(cyc), 32'd17);
    check({tag, "_value"}, two_mean_out, exp);
    @(posedge clk); #1;
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int               cyc, nv, first;
    logic [DW*NA-1:0] v;

    rst    = 1'b1;
    start  = 1'b0;
    start4 = 1'b0;
    amp_in = '0;
    amp4   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid_out}, 32'd0);
    check("reset_value", two_mean_out, 32'd0);
    check("reset_busy4", {31'd0, busy4}, 32'd0);

    run_op(fill(32'd256), "all256", 32'd512);
    repeat (3) @(posedge clk);
    #1;
    check("hold_value", two_mean_out, 32'd512);
    check("hold_valid", {31'd0, valid_out}, 32'd0);

    for (int j = 0; j < NA; j++) v[DW*j +: DW] = (j < 8) ? 32'd100 : -32'sd100;
    run_op(v, "plus_minus", 32'd0);

    run_op(ramp(0), "ramp0", 32'd15);
    run_op(ramp(-10), "ramp_neg", 32'hFFFF_FFFB);

    v = '0;
    v[DW-1:0] = 32'd4;
`ifdef GROVER_MEAN_ROUND_EN
    run_op(v, "round_pos", 32'd1);
`else
    run_op(v, "round_pos", 32'd0);
`endif
    v[DW-1:0] = 32'hFFFF_FFFF;
`ifdef GROVER_MEAN_ROUND_EN
    run_op(v, "round_neg", 32'd0);
`else
    run_op(v, "round_neg", 32'hFFFF_FFFF);
`endif

    run_op(fill(32'h7FFF_FFFF), "sat_max", 32'h7FFF_FFFF);
    run_op(fill(32'h8000_0000), "sat_min", 32'h8000_0000);

    // Second start at edge 3 must be ignored.
    amp_in = fill(32'd256);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    amp_in = fill(32'h7FFF_FFFF);
    nv    = 0;
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 2) check("busy_mid", {31'd0, busy}, 32'd1);
      if (valid_out) begin
        nv++;
        if (first == 0) first = k;
      end
    end
    check("ignore_start_count", DW'(nv), 32'd1);
    check("ignore_start_latency", DW'(first), 32'd17);
    check("ignore_start_value", two_mean_out, 32'd512);

    // Reset at edge 5 mid-operation.
    amp_in = fill(32'd100);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_value", two_mean_out, 32'd0);
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid_out) nv++;
    end
    check("midrst_no_valid", DW'(nv), 32'd0);
    run_op(ramp(0), "after_rst", 32'd15);

    // Four elements per cycle.
    amp4   = fill(32'hFFFF_FFF8);
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    amp4   = '0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!valid4 && cyc < 20);
    check("epc4_latency", DW'(cyc), 32'd5);
    check("epc4_value", two_mean4, 32'hFFFF_FFF0);
    @(posedge clk); #1;
    check("epc4_busy_after", {31'd0, busy4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
